wb_master_arbiter: RTL
======================

WB_MASTER_ARBITER -- requirements
Module: wb_master_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 2, number of Wishbone masters (2..8).
REQ-002 SHALL have parameter ADDR_W, default 32, address width.
REQ-003 SHALL have parameter DATA_W, default 32, data width; SEL_W = DATA_W/8.
REQ-004 SHALL have parameter RR_MODE, default 1; 1 = round-robin, 0 = fixed priority with lowest index winning.
REQ-005 SHALL have parameter TIMEOUT, default 255, stall cycles before bus error; 0 disables the timeout.
REQ-006 SHALL have clk  input  1  system clock; one clock domain, all logic on its rising edge.
REQ-007 SHALL have rst  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have m_cyc  input  NUM_MASTERS  per-master cycle request.
REQ-009 SHALL have m_stb, m_we  input  NUM_MASTERS each  per-master strobe and write enable.
REQ-010 SHALL have m_addr  input  NUM_MASTERS*ADDR_W  packed addresses; master i at bits [i*ADDR_W +: ADDR_W].
REQ-011 SHALL have m_dat_w  input  NUM_MASTERS*DATA_W  packed write data.
REQ-012 SHALL have m_sel  input  NUM_MASTERS*SEL_W  packed byte selects.
REQ-013 SHALL have m_ack, m_err  output  NUM_MASTERS each  per-master acknowledge and error.
REQ-014 SHALL have m_dat_r  output  DATA_W  read data, broadcast to all masters.
REQ-015 SHALL have s_cyc, s_stb, s_we  output  1 each; s_addr  output  ADDR_W; s_dat_w  output  DATA_W; s_sel  output  SEL_W; all to the shared slave.
REQ-016 SHALL have s_dat_r  input  DATA_W; s_ack, s_err  input  1 each; all from the slave.
REQ-017 SHALL have grant  output  NUM_MASTERS  registered one-hot owner, all-zero when idle.
REQ-018 SHALL have timeout_evt  output  1  single-cycle pulse when a timeout fires.

Function
REQ-019 SHALL use two states: IDLE (grant = 0) and OWNED (grant one-hot).
REQ-020 IDLE: if any m_cyc is high, SHALL load the winner into grant at the next edge and move to OWNED. Arbitration latency is 1 cycle.
REQ-021 Fixed mode: winner SHALL be the lowest requesting index.
REQ-022 RR mode: search SHALL start at last_grant+1 and wrap modulo NUM_MASTERS. last_grant SHALL update only when a grant is loaded.
REQ-023 OWNED: grant SHALL hold while m_cyc[g] is high, including across multiple stb/ack beats. The bus is locked for the whole cycle.
REQ-024 OWNED, m_cyc[g] low: SHALL re-arbitrate that cycle among all m_cyc and load the new winner at the next edge, with no idle gap. With no requesters it SHALL return to IDLE.
REQ-025 s_cyc, s_stb, s_we, s_addr, s_dat_w and s_sel SHALL be combinational copies of the granted master's signals gated by its m_cyc. They SHALL be all-zero in IDLE.
REQ-026 m_ack[i] SHALL equal s_ack & grant[i] & m_stb[i]. Non-granted masters SHALL never see ack or err.
REQ-027 m_err[i] SHALL equal (s_err | timeout_fire) & grant[i] & m_stb[i].
REQ-028 m_dat_r SHALL equal s_dat_r unconditionally.
REQ-029 Stall counter (width clog2(TIMEOUT+1)):
- SHALL increment each OWNED cycle with s_stb high and s_ack and s_err both low.
- SHALL clear on ack, on err, on stb low, and on grant change.
REQ-030 timeout_fire SHALL assert combinationally when counter == TIMEOUT and s_ack is low. The counter SHALL clear at the next edge. timeout_evt SHALL be the registered version of timeout_fire.
REQ-031 If s_ack and the timeout coincide, ack SHALL win: no err and no timeout_evt.
REQ-032 The grant-holding master dropping m_cyc mid-transfer SHALL immediately deassert s_cyc/s_stb, and any late slave ack SHALL be discarded.
REQ-033 Requests from non-granted masters SHALL wait with no effect on the slave. There SHALL be no starvation in RR mode: the maximum wait is NUM_MASTERS-1 ownership periods.

Reset
REQ-034 rst SHALL asynchronously force grant = 0, state = IDLE, stall counter = 0, timeout_evt = 0, and last_grant = NUM_MASTERS-1, so master 0 has first RR priority.
REQ-035 During and after reset, all s_* outputs, m_ack and m_err SHALL be 0. Reset mid-transfer SHALL abandon the transfer without error.

Verification (N=2, DATA_W=32, TIMEOUT=4)
REQ-036 Both m_cyc rise at cycle 0 in RR mode -> grant=01 at cycle 1. m0 drops cyc at cycle 5 -> grant=10 at cycle 6 with no IDLE cycle between.
REQ-037 Fixed mode, both requesting continuously, each releasing after one ack -> master 0 is regranted every time master 1 releases and master 0 is requesting. Master 1 gets the bus only when m_cyc[0] is low.
REQ-038 m0 writes 0xDEADBEEF to address 0x1000_0004 with sel=0xF -> the slave sees the same values. s_ack reaches m_ack[0] only and m_ack[1] stays 0.
REQ-039 Slave never acks -> m_err[0] and timeout_evt pulse once after 5 stalled stb cycles, then the counter restarts. s_ack arriving on the fire cycle -> m_ack only, no err.
REQ-040 rst asserted mid-burst at beat 3 -> grant, s_cyc and m_ack go 0 immediately. After release, the first grant goes to master 0.

Source files
------------

// File: rtl/wb_master_arbiter.sv
// Wishbone N-to-1 master arbiter: locks the shared slave to one master for a whole cyc,
// with round-robin or fixed-priority selection and a stall timeout that answers with a bus error.
module wb_master_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int RR_MODE     = 1,
  parameter int TIMEOUT     = 255,
  localparam int SEL_W      = DATA_W / 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_MASTERS-1:0]        m_cyc,
  input  logic [NUM_MASTERS-1:0]        m_stb,
  input  logic [NUM_MASTERS-1:0]        m_we,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_dat_w,
  input  logic [NUM_MASTERS*SEL_W-1:0]  m_sel,
  output logic [NUM_MASTERS-1:0]        m_ack,
  output logic [NUM_MASTERS-1:0]        m_err,
  output logic [DATA_W-1:0]             m_dat_r,
  output logic                          s_cyc,
  output logic                          s_stb,
  output logic                          s_we,
  output logic [ADDR_W-1:0]             s_addr,
  output logic [DATA_W-1:0]             s_dat_w,
  output logic [SEL_W-1:0]              s_sel,
  input  logic [DATA_W-1:0]             s_dat_r,
  input  logic                          s_ack,
  input  logic                          s_err,
  output logic [NUM_MASTERS-1:0]        grant,
  output logic                          timeout_evt
);

  localparam int IDX_W = $clog2(NUM_MASTERS);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic {IDLE, OWNED} state_t;

  state_t                 state, state_nxt;
  logic [NUM_MASTERS-1:0] grant_nxt;
  logic [IDX_W-1:0]       last_grant, last_grant_nxt, win_idx;
  logic                   win_vld, load, owner_cyc, timeout_fire;
  logic [CNT_W-1:0]       stall_cnt;

  // Winner search: fixed scans from index 0, round-robin from the slot after the last owner.
  always_comb begin
    int idx;
    idx     = 0;
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      if (RR_MODE != 0) begin
        idx = int'(last_grant) + k;
        if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      end else begin
        idx = k - 1;
      end
      if (!win_vld && m_cyc[idx[IDX_W-1:0]]) begin
        win_vld = 1'b1;
        win_idx = idx[IDX_W-1:0];
      end
    end
  end

  assign owner_cyc = |(grant & m_cyc);

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    load           = 1'b0;
    case (state)
      IDLE: load = win_vld;
      OWNED: begin
        if (!owner_cyc) begin
          load = win_vld;
          if (!win_vld) begin
            state_nxt = IDLE;
            grant_nxt = '0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (load) begin
      state_nxt      = OWNED;
      grant_nxt      = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << win_idx;
      last_grant_nxt = win_idx;
    end
  end

  // grant is one-hot or zero, so an OR over the gated masters is the mux.
  always_comb begin
    s_cyc   = 1'b0;
    s_stb   = 1'b0;
    s_we    = 1'b0;
    s_addr  = '0;
    s_dat_w = '0;
    s_sel   = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant[i] && m_cyc[i]) begin
        s_cyc   = 1'b1;
        s_stb   = m_stb[i];
        s_we    = m_we[i];
        s_addr  = m_addr[i*ADDR_W +: ADDR_W];
        s_dat_w = m_dat_w[i*DATA_W +: DATA_W];
        s_sel   = m_sel[i*SEL_W +: SEL_W];
      end
    end
  end

  assign timeout_fire = (TIMEOUT != 0) && s_stb && !s_ack && (stall_cnt == CNT_W'(TIMEOUT));

  // Gating by m_cyc drops a late slave ack after the owner abandoned its cycle.
  assign m_ack   = {NUM_MASTERS{s_ack}} & grant & m_cyc & m_stb;
  assign m_err   = {NUM_MASTERS{s_err | timeout_fire}} & grant & m_cyc & m_stb;
  assign m_dat_r = s_dat_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= '0;
      last_grant  <= IDX_W'(NUM_MASTERS - 1);
      stall_cnt   <= '0;
      timeout_evt <= 1'b0;
    end else begin
      state       <= state_nxt;
      grant       <= grant_nxt;
      last_grant  <= last_grant_nxt;
      timeout_evt <= timeout_fire;
      if (load || !s_stb || s_ack || s_err || timeout_fire)
        stall_cnt <= '0;
      else
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule
